// File: rtl/doorbell_flash_sequencer.sv
// Doorbell light-mux sequencer: a button press runs NUM_FLASHES on/off flashes,
// stepping the RGB colour red -> green -> blue on every flash.
module doorbell_flash_sequencer #(
    parameter int PHASE_CYCLES = 10,
    parameter int NUM_FLASHES  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button,
    input  logic        enable,
    output logic        sel,
    output logic [23:0] rgb,
    output logic        busy,
    output logic        done
);

    localparam int TW = $clog2(PHASE_CYCLES);
    localparam int FW = $clog2(NUM_FLASHES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(PHASE_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(NUM_FLASHES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t          state_reg;
    logic            button_q;
    logic [TW-1:0]   timer_reg;
    logic [FW-1:0]   flash_cnt_reg;
    logic [1:0]      colour_idx_reg;
    logic            press;
    logic [1:0]      colour_idx_next;

    function automatic logic [23:0] colour_of(input logic [1:0] idx);
        case (idx)
            2'd0:    colour_of = 24'hFF0000;
            2'd1:    colour_of = 24'h00FF00;
            default: colour_of = 24'h0000FF;
        endcase
    endfunction

    // Rising edge of the level button; a held button gives a single press.
    assign press           = button & ~button_q;
    assign colour_idx_next = (colour_idx_reg == 2'd2) ? 2'd0 : colour_idx_reg + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            button_q       <= 1'b0;
            timer_reg      <= '0;
            flash_cnt_reg  <= '0;
            colour_idx_reg <= 2'd0;
            sel            <= 1'b0;
            rgb            <= 24'h000000;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            button_q <= button;
            done     <= 1'b0;
            if (state_reg != IDLE && !enable) begin
                // Abort: drop to idle without a done pulse, colour is left as-is.
                state_reg <= IDLE;
                timer_reg <= '0;
                sel       <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (press && enable) begin
                            state_reg      <= ON;
                            timer_reg      <= '0;
                            flash_cnt_reg  <= '0;
                            colour_idx_reg <= 2'd0;
                            rgb            <= colour_of(2'd0);
                            sel            <= 1'b1;
                            busy           <= 1'b1;
                        end
                    end
                    ON: begin
                        if (timer_reg == TIMER_LAST) begin
                            timer_reg <= '0;
                            state_reg <= OFF;
                            sel       <= 1'b0;
                        end else begin
                            timer_reg <= timer_reg + 1'b1;
                        end
                    end
                    OFF: begin
                        if (timer_reg == TIMER_LAST) begin
                            timer_reg <= '0;
                            if (flash_cnt_reg == FLASH_LAST) begin
                                state_reg <= IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                flash_cnt_reg  <= flash_cnt_reg + 1'b1;
                                colour_idx_reg <= colour_idx_next;
                                rgb            <= colour_of(colour_idx_next);
                                state_reg      <= ON;
                                sel            <= 1'b1;
                            end
                        end else begin
                            timer_reg <= timer_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        sel       <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
